riscv_core_divider: RTL and testbench

Sequential radix-2 restoring integer divider for the RV64M execute stage, the inverse companion of the shift-add multiplier. It executes DIV/DIVU/REM/REMU and the word forms DIVW/DIVUW/REMW/REMUW. It produces quotient and remainder together over one iteration per cycle, resolves RISC-V special cases without iterating, and signals completion with a one-cycle done pulse.

---
 rtl/riscv_core_div_pkg.sv | 35 +++
 rtl/riscv_core_div_prep.sv | 64 ++++++
 rtl/riscv_core_divider.sv | 181 ++++++++++++++++++
 tb/tb_riscv_core_divider.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_div_pkg.sv
// -----------------------------------------------------------------------------
// riscv_core_div_pkg
// Shared definitions for the RV64M sequential divider: datapath width,
// FSM state encoding, iteration counts and special-case result constants.
// -----------------------------------------------------------------------------
package riscv_core_div_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = 7;

    // Iterations per operation: one quotient bit per cycle.
    localparam logic [CNT_W-1:0] ITER_DWORD = 7'd64;
    localparam logic [CNT_W-1:0] ITER_WORD  = 7'd32;

    // Divide-by-zero quotient is all-ones in both widths (the word form
    // 0xFFFF_FFFF sign-extends to all-ones as well).
    localparam logic [XLEN-1:0] DIV0_QUOTIENT = {XLEN{1'b1}};
    // Overflow (most-negative / -1) leaves a zero remainder.
    localparam logic [XLEN-1:0] OVF_REMAINDER = {XLEN{1'b0}};

    // Most-negative dividends, already extended to XLEN.
    localparam logic [XLEN-1:0] MOST_NEG_DWORD = 64'h8000_0000_0000_0000;
    localparam logic [XLEN-1:0] MOST_NEG_WORD  = 64'hFFFF_FFFF_8000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2
    } div_state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/riscv_core_div_prep.sv
// -----------------------------------------------------------------------------
// riscv_core_div_prep
// Combinational operand preparation for the divider.
//   dividend_i / divisor_i  : raw XLEN operands
//   signed_i                : two's complement semantics
//   word_i                  : operate on bits [31:0]
//   dividend_mag_o          : |dividend| after width handling
//   divisor_mag_o           : |divisor|  after width handling
//   dividend_ext_o          : dividend as a final result value (word: sign-
//                             extended from bit 31 regardless of signed_i)
//   quot_neg_o / rem_neg_o  : result signs to restore after iterating
//   div_zero_o / overflow_o : special cases resolved without iterating
// -----------------------------------------------------------------------------
module riscv_core_div_prep
    import riscv_core_div_pkg::*;
(
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            signed_i,
    input  logic            word_i,
    output logic [XLEN-1:0] dividend_mag_o,
    output logic [XLEN-1:0] divisor_mag_o,
    output logic [XLEN-1:0] dividend_ext_o,
    output logic            quot_neg_o,
    output logic            rem_neg_o,
    output logic            div_zero_o,
    output logic            overflow_o
);

    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] most_neg;

    always_comb begin
        // Operand view in the working width: word forms extend bit 31 only
        // when the operation is signed.
        if (word_i) begin
            a_ext = signed_i ? sext32(dividend_i[31:0]) : {32'b0, dividend_i[31:0]};
            b_ext = signed_i ? sext32(divisor_i[31:0])  : {32'b0, divisor_i[31:0]};
        end else begin
            a_ext = dividend_i;
            b_ext = divisor_i;
        end

        a_neg = signed_i & a_ext[XLEN-1];
        b_neg = signed_i & b_ext[XLEN-1];

        dividend_mag_o = a_neg ? -a_ext : a_ext;
        divisor_mag_o  = b_neg ? -b_ext : b_ext;

        // Results of word ops are always sign-extended, even DIVUW/REMUW.
        dividend_ext_o = word_i ? sext32(dividend_i[31:0]) : dividend_i;

        quot_neg_o = a_neg ^ b_neg;
        rem_neg_o  = a_neg;

        most_neg   = word_i ? MOST_NEG_WORD : MOST_NEG_DWORD;
        div_zero_o = (b_ext == '0);
        overflow_o = signed_i && (a_ext == most_neg) && (b_ext == {XLEN{1'b1}});
    end

endmodule

// File: rtl/riscv_core_divider.sv
// -----------------------------------------------------------------------------
// riscv_core_divider
// Radix-2 restoring divider for DIV/DIVU/REM/REMU and the W forms. One
// quotient bit per cycle; special cases bypass iteration.
//   i_div_clk, i_div_rstn           : clock, synchronous active-low reset
//   i_div_en                        : start request, accepted only in IDLE
//   i_div_dividend, i_div_divisor   : operands, sampled on the accept edge
//   i_div_signed, i_div_word        : operation flavour
//   o_div_busy                      : operation in flight (through done cycle)
//   o_div_done                      : one-cycle completion pulse
//   o_div_quotient, o_div_remainder : registered results, held until next done
// Handshake: a request is taken on any rising edge where i_div_en=1 and the
// FSM is IDLE (including the done cycle); requests at other times are
// dropped, and the caller must watch o_div_done for the result.
// -----------------------------------------------------------------------------
module riscv_core_divider
    import riscv_core_div_pkg::*;
(
    input  logic            i_div_clk,
    input  logic            i_div_rstn,
    input  logic            i_div_en,
    input  logic [XLEN-1:0] i_div_dividend,
    input  logic [XLEN-1:0] i_div_divisor,
    input  logic            i_div_signed,
    input  logic            i_div_word,
    output logic            o_div_busy,
    output logic            o_div_done,
    output logic [XLEN-1:0] o_div_quotient,
    output logic [XLEN-1:0] o_div_remainder
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]    rem_q, rem_d;       // partial remainder, XLEN+1 bits
    logic [XLEN-1:0]  quo_q, quo_d;       // dividend shifting out, quotient in
    logic [XLEN-1:0]  dvs_q, dvs_d;       // divisor magnitude
    logic             quot_neg_q, quot_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             word_q, word_d;
    logic [XLEN-1:0]  quotient_q, quotient_d;
    logic [XLEN-1:0]  remainder_q, remainder_d;
    logic             done_q, done_d;

    logic [XLEN-1:0]  dividend_mag;
    logic [XLEN-1:0]  divisor_mag;
    logic [XLEN-1:0]  dividend_ext;
    logic             quot_neg;
    logic             rem_neg;
    logic             div_zero;
    logic             overflow;

    logic [XLEN+1:0]  shifted;
    logic [XLEN+1:0]  trial;
    logic [XLEN-1:0]  fix_quo;
    logic [XLEN-1:0]  fix_rem;

    riscv_core_div_prep u_prep (
        .dividend_i     (i_div_dividend),
        .divisor_i      (i_div_divisor),
        .signed_i       (i_div_signed),
        .word_i         (i_div_word),
        .dividend_mag_o (dividend_mag),
        .divisor_mag_o  (divisor_mag),
        .dividend_ext_o (dividend_ext),
        .quot_neg_o     (quot_neg),
        .rem_neg_o      (rem_neg),
        .div_zero_o     (div_zero),
        .overflow_o     (overflow)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        quot_neg_d  = quot_neg_q;
        rem_neg_d   = rem_neg_q;
        word_d      = word_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;

        // {R,Q} << 1 with the next dividend bit entering R; the extra top
        // bit makes trial's sign bit a direct "R < D" flag.
        shifted = {rem_q, quo_q[XLEN-1]};
        trial   = shifted - {2'b00, dvs_q};

        fix_quo = quot_neg_q ? -quo_q : quo_q;
        fix_rem = rem_neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        if (word_q) begin
            fix_quo = sext32(fix_quo[31:0]);
            fix_rem = sext32(fix_rem[31:0]);
        end

        case (state_q)
            S_IDLE: begin
                if (i_div_en) begin
                    dvs_d  = divisor_mag;
                    word_d = i_div_word;
                    cnt_d  = i_div_word ? ITER_WORD : ITER_DWORD;
                    if (div_zero || overflow) begin
                        // Final values are loaded directly; FIX only
                        // registers them (signs cleared so no negation).
                        quo_d      = div_zero ? DIV0_QUOTIENT : dividend_ext;
                        rem_d      = {1'b0, div_zero ? dividend_ext : OVF_REMAINDER};
                        quot_neg_d = 1'b0;
                        rem_neg_d  = 1'b0;
                        state_d    = S_FIX;
                    end else begin
                        // Word dividend is left-aligned so the same MSB-first
                        // shift works for both widths.
                        quo_d      = i_div_word ? {dividend_mag[31:0], 32'b0} : dividend_mag;
                        rem_d      = '0;
                        quot_neg_d = quot_neg;
                        rem_neg_d  = rem_neg;
                        state_d    = S_DIV;
                    end
                end
            end
            S_DIV: begin
                if (!trial[XLEN+1]) begin
                    rem_d = trial[XLEN:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = shifted[XLEN:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 7'd1) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                quotient_d  = fix_quo;
                remainder_d = fix_rem;
                done_d      = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_div_clk) begin
        if (!i_div_rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quot_neg_q  <= 1'b0;
            rem_neg_q   <= 1'b0;
            word_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            quot_neg_q  <= quot_neg_d;
            rem_neg_q   <= rem_neg_d;
            word_q      <= word_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
        end
    end

    // The done cycle is already IDLE but still counts as part of the
    // operation for busy.
    assign o_div_busy      = (state_q != S_IDLE) || done_q;
    assign o_div_done      = done_q;
    assign o_div_quotient  = quotient_q;
    assign o_div_remainder = remainder_q;

endmodule

// File: tb/tb_riscv_core_divider.sv
module tb_riscv_core_divider;

    logic        clk;
    logic        rstn;
    logic        en;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        sgn;
    logic        word;
    logic        busy;
    logic        done;
    logic [63:0] quot;
    logic [63:0] rem;

    int checks = 0;
    int errors = 0;

    riscv_core_divider dut (
        .i_div_clk       (clk),
        .i_div_rstn      (rstn),
        .i_div_en        (en),
        .i_div_dividend  (dividend),
        .i_div_divisor   (divisor),
        .i_div_signed    (sgn),
        .i_div_word      (word),
        .o_div_busy      (busy),
        .o_div_done      (done),
        .o_div_quotient  (quot),
        .o_div_remainder (rem)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver ----------------
    // Starts in the current cycle (caller sits #1 after a rising edge), then
    // counts edges after the accept edge until done is seen. lat=0 on timeout.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                         input logic s, input logic w,
                         output int lat, output logic [63:0] q,
                         output logic [63:0] r, output bit busy_ok);
        en = 1'b1; dividend = a; divisor = b; sgn = s; word = w;
        @(posedge clk); #1;
        en = 1'b0;
        // operands may change after acceptance
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
        sgn = 1'($urandom_range(0, 1));
        word = 1'($urandom_range(0, 1));
        busy_ok = 1'b1; lat = 0; q = '0; r = '0;
        for (int k = 1; k <= 200; k++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            if (done === 1'b1) begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                lat = k; q = quot; r = rem;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0; en = 1'b0; dividend = '0; divisor = '0; sgn = 1'b0; word = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (quot !== 64'h0) begin errors++; $display("FAIL reset_quot got %h want 0", quot); end
        checks++; if (rem !== 64'h0) begin errors++; $display("FAIL reset_rem got %h want 0", rem); end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_divu();
        int lat; logic [63:0] q, r; bit bok;
        do_op(64'd100, 64'd7, 1'b0, 1'b0, lat, q, r, bok);
        checks++; if (lat != 65) begin errors++; $display("FAIL divu_latency got %0d want 65", lat); end
        checks++; if (q !== 64'd14) begin errors++; $display("FAIL divu_quot got %h want e", q); end
        checks++; if (r !== 64'd2) begin errors++; $display("FAIL divu_rem got %h want 2", r); end
        checks++; if (!bok) begin errors++; $display("FAIL divu_busy got low want high"); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL divu_done_pulse got %0b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divu_busy_after got %0b want 0", busy); end
        repeat (3) @(posedge clk); #1;
        checks++; if (quot !== 64'd14 || rem !== 64'd2) begin
            errors++; $display("FAIL divu_hold got %h/%h want e/2", quot, rem); end
    endtask

    task automatic test_signed();
        int lat; logic [63:0] q, r; bit bok;
        do_op(-64'sd7, 64'd2, 1'b1, 1'b0, lat, q, r, bok);
        checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_neg_quot got %h want fffffffffffffffd", q); end
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL div_neg_rem got %h want ffffffffffffffff", r); end
        do_op(64'd7, -64'sd2, 1'b1, 1'b0, lat, q, r, bok);
        checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_negd_quot got %h want fffffffffffffffd", q); end
        checks++; if (r !== 64'd1) begin errors++; $display("FAIL div_negd_rem got %h want 1", r); end
        checks++; if (lat != 65) begin errors++; $display("FAIL div_signed_latency got %0d want 65", lat); end
        // DIVW -100 / 7 = -14 rem -2
        do_op(-64'sd100, 64'd7, 1'b1, 1'b1, lat, q, r, bok);
        checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFF2) begin errors++; $display("FAIL divw_quot got %h want fffffffffffffff2", q); end
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL divw_rem got %h want fffffffffffffffe", r); end
        checks++; if (lat != 33) begin errors++; $display("FAIL divw_latency got %0d want 33", lat); end
    endtask

    task automatic test_unsigned_big();
        int lat; logic [63:0] q, r; bit bok;
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, 1'b0, lat, q, r, bok);
        checks++; if (q !== 64'h0FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL divu_big_quot got %h want 0fffffffffffffff", q); end
        checks++; if (r !== 64'hF) begin errors++; $display("FAIL divu_big_rem got %h want f", r); end
    endtask

    task automatic test_div_zero();
        int lat; logic [63:0] q, r; bit bok;
        do_op(64'd42, 64'd0, 1'b1, 1'b0, lat, q, r, bok);
        checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL div0_quot got %h want all-ones", q); end
        checks++; if (r !== 64'd42) begin errors++; $display("FAIL div0_rem got %h want 2a", r); end
        checks++; if (lat != 1) begin errors++; $display("FAIL div0_latency got %0d want 1", lat); end
        checks++; if (!bok) begin errors++; $display("FAIL div0_busy got low want high"); end
        do_op(64'd5, 64'd0, 1'b0, 1'b1, lat, q, r, bok);
        checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL divuw0_quot got %h want all-ones", q); end
        checks++; if (r !== 64'd5) begin errors++; $display("FAIL divuw0_rem got %h want 5", r); end
        checks++; if (lat != 1) begin errors++; $display("FAIL divuw0_latency got %0d want 1", lat); end
    endtask

    task automatic test_overflow();
        int lat; logic [63:0] q, r; bit bok;
        do_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, lat, q, r, bok);
        checks++; if (q !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_quot got %h want 8000000000000000", q); end
        checks++; if (r !== 64'h0) begin errors++; $display("FAIL ovf_rem got %h want 0", r); end
        checks++; if (lat != 1) begin errors++; $display("FAIL ovf_latency got %0d want 1", lat); end
        do_op(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, lat, q, r, bok);
        checks++; if (q !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL ovfw_quot got %h want ffffffff80000000", q); end
        checks++; if (r !== 64'h0) begin errors++; $display("FAIL ovfw_rem got %h want 0", r); end
        checks++; if (lat != 1) begin errors++; $display("FAIL ovfw_latency got %0d want 1", lat); end
    endtask

    task automatic test_word();
        int lat; logic [63:0] q, r; bit bok;
        do_op(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1, lat, q, r, bok);
        checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL divuw_quot got %h want all-ones", q); end
        checks++; if (r !== 64'h0) begin errors++; $display("FAIL divuw_rem got %h want 0", r); end
        checks++; if (lat != 33) begin errors++; $display("FAIL divuw_latency got %0d want 33", lat); end
        checks++; if (!bok) begin errors++; $display("FAIL divuw_busy got low want high"); end
        do_op(64'h1234_5678_0000_000A, 64'd3, 1'b0, 1'b1, lat, q, r, bok);
        checks++; if (r !== 64'd1) begin errors++; $display("FAIL remuw_rem got %h want 1", r); end
        checks++; if (q !== 64'd3) begin errors++; $display("FAIL remuw_quot got %h want 3", q); end
        do_op(64'hABCD_0000_8000_0000, 64'd1, 1'b0, 1'b1, lat, q, r, bok);
        checks++; if (q !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL divuw_sext_quot got %h want ffffffff80000000", q); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [63:0] q, r; bit bok;
        do_op(64'd1000, 64'd10, 1'b0, 1'b0, lat, q, r, bok);
        checks++; if (q !== 64'd100 || r !== 64'd0) begin errors++; $display("FAIL b2b_first got %h/%h want 64/0", q, r); end
        // issued in the done cycle
        do_op(64'd81, 64'd9, 1'b0, 1'b0, lat, q, r, bok);
        checks++; if (lat != 65) begin errors++; $display("FAIL b2b_latency got %0d want 65", lat); end
        checks++; if (q !== 64'd9 || r !== 64'd0) begin errors++; $display("FAIL b2b_second got %h/%h want 9/0", q, r); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [63:0] q, r; bit bok; bit saw_done;
        saw_done = 1'b0;
        en = 1'b1; dividend = 64'd100; divisor = 64'd7; sgn = 1'b0; word = 1'b0;
        @(posedge clk); #1;
        en = 1'b0;
        for (int c = 1; c < 20; c++) begin
            if (c == 10) begin
                en = 1'b1; dividend = 64'd5; divisor = 64'd0;
            end else begin
                en = 1'b0;
            end
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        en = 1'b0;
        rstn = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %0b want 0", done); end
        checks++; if (quot !== 64'h0 || rem !== 64'h0) begin
            errors++; $display("FAIL midrst_outputs got %h/%h want 0/0", quot, rem); end
        rstn = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL midrst_no_done got pulse want none"); end
        do_op(64'd100, 64'd7, 1'b0, 1'b0, lat, q, r, bok);
        checks++; if (lat != 65 || q !== 64'd14 || r !== 64'd2) begin
            errors++; $display("FAIL midrst_fresh got lat=%0d %h/%h want 65 e/2", lat, q, r); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_unsigned_big();
        test_div_zero();
        test_overflow();
        test_word();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
